wptr_full_gen: RTL and testbench

// - Write-domain pointer/full-flag generator for the async FIFO; sits directly upstream of the
//   2-FF pointer synchronizer that carries wptr into the read domain.
// - Keeps the binary write counter, drives the memory write address, publishes a registered Gray

---
 rtl/wptr_full_gen.sv | 80 ++++++++
 tb/tb_wptr_full_gen.sv | 139 +++++++++++++
 2 files changed

// File: rtl/wptr_full_gen.sv
// Async FIFO write-side pointer/full generator: binary count, registered Gray wptr, wfull; updates on the accepting edge.
// Writes while full are dropped (wen=0); optional walmost_full under `ALMOST_FULL_EN`, released as pessimistically as wfull.
module wptr_full_gen #(
  parameter int unsigned addr_size_p = 8
`ifdef ALMOST_FULL_EN
  , parameter int unsigned almost_full_thresh_p = 2**addr_size_p - 2
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   winc,
  input  logic [addr_size_p:0]   wq2_rptr,
  output logic                   wen,
  output logic [addr_size_p-1:0] waddr,
  output logic [addr_size_p:0]   wptr,
  output logic                   wfull
`ifdef ALMOST_FULL_EN
  , output logic                 walmost_full
`endif
);

  logic [addr_size_p:0] wbin_q, wbin_d;
  logic [addr_size_p:0] wptr_q, wgray_d;
  logic [addr_size_p:0] rptr_full_cmp;
  logic                 wfull_q, wfull_d;

  // Reset cycle swallows winc so nothing reaches memory while the pointer restarts.
  assign wen     = winc & ~wfull_q & ~rst;
  assign wbin_d  = wbin_q + {{addr_size_p{1'b0}}, wen};
  assign wgray_d = (wbin_d >> 1) ^ wbin_d;

  // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
  assign rptr_full_cmp = {~wq2_rptr[addr_size_p:addr_size_p-1], wq2_rptr[addr_size_p-2:0]};
  assign wfull_d       = (wgray_d == rptr_full_cmp);

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      wfull_q <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wgray_d;
      wfull_q <= wfull_d;
    end
  end

  assign waddr = wbin_q[addr_size_p-1:0];
  assign wptr  = wptr_q;
  assign wfull = wfull_q;

`ifdef ALMOST_FULL_EN
  localparam logic [addr_size_p:0] AfThresh = (addr_size_p+1)'(almost_full_thresh_p);

  logic [addr_size_p:0] rbin_s;
  logic [addr_size_p:0] level;
  logic                 walmost_full_q, walmost_full_d;

  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= addr_size_p; i++) begin
      rbin_s[i] = ^(wq2_rptr >> i);
    end
  end

  assign level          = wbin_d - rbin_s;
  assign walmost_full_d = (level >= AfThresh);

  always_ff @(posedge clk) begin
    if (rst) begin
      walmost_full_q <= 1'b0;
    end else begin
      walmost_full_q <= walmost_full_d;
    end
  end

  assign walmost_full = walmost_full_q;
`endif

endmodule

// File: tb/tb_wptr_full_gen.sv
// Directed vector bench for wptr_full_gen at depth 4 (addr_size_p=2).
module tb_wptr_full_gen;

  logic       clk;
  logic       rst;
  logic       winc;
  logic [2:0] wq2_rptr;
  logic       wen;
  logic [1:0] waddr;
  logic [2:0] wptr;
  logic       wfull;
`ifdef ALMOST_FULL_EN
  logic       walmost_full;
`endif

  int checks = 0;
  int errors = 0;

  wptr_full_gen #(
    .addr_size_p(2)
`ifdef ALMOST_FULL_EN
    , .almost_full_thresh_p(3)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .winc     (winc),
    .wq2_rptr (wq2_rptr),
    .wen      (wen),
    .waddr    (waddr),
    .wptr     (wptr),
    .wfull    (wfull)
`ifdef ALMOST_FULL_EN
    , .walmost_full(walmost_full)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       winc;
    logic [2:0] rq;
    logic       wen;
    logic [2:0] wptr;
    logic [1:0] waddr;
    logic       wfull;
  } vec_t;

  vec_t       vt[12];
  logic [2:0] gtab[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // wen is checked before the edge; registered outputs #1 after it.
  task automatic apply(input vec_t v, input string tag);
    rst      = v.rst;
    winc     = v.winc;
    wq2_rptr = v.rq;
    #1;
    chk({tag, ".wen"}, {31'd0, wen}, {31'd0, v.wen});
    @(posedge clk);
    #1;
    chk({tag, ".wptr"},  {29'd0, wptr},  {29'd0, v.wptr});
    chk({tag, ".waddr"}, {30'd0, waddr}, {30'd0, v.waddr});
    chk({tag, ".wfull"}, {31'd0, wfull}, {31'd0, v.wfull});
  endtask

  initial begin
    vec_t v;
    int   idx;

    gtab = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    //          rst   winc  rq      wen   wptr    waddr wfull
    vt[0]  = '{1'b1, 1'b1, 3'b000, 1'b0, 3'b000, 2'd0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 3'b000, 1'b0, 3'b000, 2'd0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 3'b000, 1'b1, 3'b001, 2'd1, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 3'b000, 1'b1, 3'b011, 2'd2, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 3'b000, 1'b1, 3'b010, 2'd3, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 3'b000, 1'b1, 3'b110, 2'd0, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 3'b000, 1'b0, 3'b110, 2'd0, 1'b1};
    vt[7]  = '{1'b0, 1'b1, 3'b000, 1'b0, 3'b110, 2'd0, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 3'b000, 1'b0, 3'b110, 2'd0, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 3'b001, 1'b0, 3'b110, 2'd0, 1'b0};
    vt[10] = '{1'b0, 1'b1, 3'b001, 1'b1, 3'b111, 2'd1, 1'b1};
    vt[11] = '{1'b0, 1'b1, 3'b001, 1'b0, 3'b111, 2'd1, 1'b1};

    rst = 1'b1;
    winc = 1'b0;
    wq2_rptr = 3'b000;

    for (int i = 0; i < 12; i++) begin
      apply(vt[i], $sformatf("vec%0d", i));
    end

    // Streaming with the read pointer trailing two cycles behind: wraps, never full.
    apply('{1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 2'd0, 1'b0}, "stream_rst");
    for (int k = 1; k <= 8; k++) begin
      idx = k - 3;
      v.rst   = 1'b0;
      v.winc  = 1'b1;
      v.rq    = (idx >= 0) ? gtab[idx] : 3'b000;
      v.wen   = 1'b1;
      v.wptr  = gtab[k % 8];
      v.waddr = 2'(k % 4);
      v.wfull = 1'b0;
      apply(v, $sformatf("stream%0d", k));
    end

    // Reset mid-operation with winc held high.
    apply('{1'b0, 1'b1, 3'b000, 1'b1, 3'b001, 2'd1, 1'b0}, "mid_w1");
    apply('{1'b0, 1'b1, 3'b000, 1'b1, 3'b011, 2'd2, 1'b0}, "mid_w2");
    apply('{1'b1, 1'b1, 3'b000, 1'b0, 3'b000, 2'd0, 1'b0}, "mid_rst");
    apply('{1'b0, 1'b1, 3'b000, 1'b1, 3'b001, 2'd1, 1'b0}, "post_rst");

`ifdef ALMOST_FULL_EN
    apply('{1'b1, 1'b0, 3'b000, 1'b0, 3'b000, 2'd0, 1'b0}, "af_rst");
    chk("af_rst.walmost_full", {31'd0, walmost_full}, 32'd0);
    apply('{1'b0, 1'b1, 3'b000, 1'b1, 3'b001, 2'd1, 1'b0}, "af_w1");
    chk("af_w1.walmost_full", {31'd0, walmost_full}, 32'd0);
    apply('{1'b0, 1'b1, 3'b000, 1'b1, 3'b011, 2'd2, 1'b0}, "af_w2");
    chk("af_w2.walmost_full", {31'd0, walmost_full}, 32'd0);
    apply('{1'b0, 1'b1, 3'b000, 1'b1, 3'b010, 2'd3, 1'b0}, "af_w3");
    chk("af_w3.walmost_full", {31'd0, walmost_full}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
